axis_mem_writer: RTL and testbench

- Streaming capture stage directly upstream of the mem block's S_AXI_MEM_0 slave.
- Packs a 64-bit AXI-Stream (the PR region's M_AXIS output) into 512-bit lines and writes each line as a single-beat AXI4 INCR write into a circular region of DDR.
- Exposes the write pointer, packet/line counters and a sticky error flag so the control plane can read back captured traffic.

---
 rtl/axis_mem_writer_pkg.sv | 23 ++
 rtl/axis_mem_writer_if.sv | 59 +++++
 rtl/axis_mem_writer_packer.sv | 69 ++++++
 rtl/axis_mem_writer.sv | 126 ++++++++++++
 tb/tb_axis_mem_writer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_mem_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_mem_pkg
// Brief   : Shared types and AXI constants for the stream-to-DDR line writer.
// Revision: 1.0
// ============================================================================
package axis_mem_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } wr_state_e;

  localparam logic [2:0] AXI_SIZE_64B         = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0011;

  localparam int LANES = 8;

endpackage
`default_nettype wire

// File: rtl/axis_mem_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : axis_stream_if / axi_mem_wr_if
// Brief   : AXI-Stream input and AXI4 write-channel bundles with modports.
// Revision: 1.0
// ============================================================================
interface axis_stream_if #(
  parameter int DATA_W = 64
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface axi_mem_wr_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 512
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awlock;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axis_mem_writer_packer.sv
`default_nettype none
// ============================================================================
// Module  : axis_line_packer
// Brief   : Packs stream beats into one wide line plus strobes; holds it until acked.
// Revision: 1.0
// ============================================================================
module axis_line_packer
  import axis_mem_pkg::*;
#(
  parameter int STREAM_WIDTH = 64,
  parameter int LINE_WIDTH   = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axis_stream_if.slave            s_axis,
  output logic                    line_valid_o,
  input  logic                    line_ack_i,
  output logic [LINE_WIDTH-1:0]   line_data_o,
  output logic [LINE_WIDTH/8-1:0] line_strb_o,
  output logic                    line_last_o
);

  localparam int KEEP_W = STREAM_WIDTH / 8;
  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0]       lane_q;
  logic                    held_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic [LINE_WIDTH/8-1:0] strb_q;
  logic                    last_q;
  logic                    beat;

  // Ready is gated by reset so the upstream sees no acceptance while held in reset.
  assign s_axis.tready = rst_n & ~held_q;
  assign beat          = s_axis.tvalid & s_axis.tready;
  assign line_valid_o  = beat & (s_axis.tlast | (lane_q == LANE_W'(LANES - 1)));

  assign line_data_o = data_q;
  assign line_strb_o = strb_q;
  assign line_last_o = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      held_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
    end else if (line_ack_i) begin
      lane_q <= '0;
      held_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
    end else if (beat) begin
      data_q[int'(lane_q)*STREAM_WIDTH +: STREAM_WIDTH] <= s_axis.tdata;
      strb_q[int'(lane_q)*KEEP_W +: KEEP_W]             <= s_axis.tkeep;
      if (line_valid_o) begin
        lane_q <= '0;
        held_q <= 1'b1;
        last_q <= s_axis.tlast;
      end else begin
        lane_q <= lane_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_mem_writer.sv
`default_nettype none
// ============================================================================
// Module  : axis_mem_writer
// Brief   : Captures a 64-bit stream as 512-bit single-beat AXI4 writes into a circular DDR region.
// Revision: 1.0
// ============================================================================
module axis_mem_writer
  import axis_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 15,
  parameter int                    LINE_WIDTH   = 512,
  parameter int                    STREAM_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                  CLK,
  input  logic                  ARESETN,
  axis_stream_if.slave          S_AXIS,
  axi_mem_wr_if.master          M_AXI_MEM,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [15:0]           pkt_count,
  output logic [15:0]           line_count,
  output logic                  wr_error
);

  wr_state_e               state_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_d;
  logic [15:0]             pkt_count_q;
  logic [15:0]             line_count_q;
  logic                    wr_error_q;

  logic                    line_close;
  logic                    line_last;
  logic [LINE_WIDTH-1:0]   line_data;
  logic [LINE_WIDTH/8-1:0] line_strb;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;

  axis_line_packer #(
    .STREAM_WIDTH (STREAM_WIDTH),
    .LINE_WIDTH   (LINE_WIDTH)
  ) u_packer (
    .clk          (CLK),
    .rst_n        (ARESETN),
    .s_axis       (S_AXIS),
    .line_valid_o (line_close),
    .line_ack_i   (b_hs),
    .line_data_o  (line_data),
    .line_strb_o  (line_strb),
    .line_last_o  (line_last)
  );

  assign aw_hs = awvalid_q & M_AXI_MEM.awready;
  assign w_hs  = wvalid_q & M_AXI_MEM.wready;
  assign b_hs  = bready_q & M_AXI_MEM.bvalid;

  // Region is a power of two, so the natural adder overflow is the wrap.
  assign wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(LINE_WIDTH / 8);

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= FILL;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      wr_ptr_q     <= BASE_ADDR;
      pkt_count_q  <= '0;
      line_count_q <= '0;
      wr_error_q   <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (line_close) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if ((aw_hs | ~awvalid_q) & (w_hs | ~wvalid_q)) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            bready_q     <= 1'b0;
            wr_ptr_q     <= wr_ptr_d;
            line_count_q <= line_count_q + 16'd1;
            if (line_last) pkt_count_q <= pkt_count_q + 16'd1;
            if (M_AXI_MEM.bresp != AXI_RESP_OKAY) wr_error_q <= 1'b1;
            state_q      <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign M_AXI_MEM.awaddr  = wr_ptr_q;
  assign M_AXI_MEM.awlen   = 8'd0;
  assign M_AXI_MEM.awsize  = AXI_SIZE_64B;
  assign M_AXI_MEM.awburst = AXI_BURST_INCR;
  assign M_AXI_MEM.awcache = AXI_CACHE_MODIFIABLE;
  assign M_AXI_MEM.awprot  = 3'd0;
  assign M_AXI_MEM.awlock  = 1'b0;
  assign M_AXI_MEM.awvalid = awvalid_q;
  assign M_AXI_MEM.wdata   = line_data;
  assign M_AXI_MEM.wstrb   = line_strb;
  assign M_AXI_MEM.wlast   = 1'b1;
  assign M_AXI_MEM.wvalid  = wvalid_q;
  assign M_AXI_MEM.bready  = bready_q;

  assign wr_ptr     = wr_ptr_q;
  assign pkt_count  = pkt_count_q;
  assign line_count = line_count_q;
  assign wr_error   = wr_error_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_mem_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_mem_writer
// Brief   : Directed self-checking bench for axis_mem_writer with a responsive AXI slave.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axis_mem_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_stream_if #(.DATA_W(64)) axs ();
  axi_mem_wr_if #(.ADDR_W(15), .DATA_W(512)) axi ();

  logic [14:0] wr_ptr;
  logic [15:0] pkt_count;
  logic [15:0] line_count;
  logic        wr_error;

  axis_mem_writer #(
    .ADDR_WIDTH   (15),
    .LINE_WIDTH   (512),
    .STREAM_WIDTH (64),
    .BASE_ADDR    (15'h0000)
  ) dut (
    .CLK        (clk),
    .ARESETN    (rst_n),
    .S_AXIS     (axs),
    .M_AXI_MEM  (axi),
    .wr_ptr     (wr_ptr),
    .pkt_count  (pkt_count),
    .line_count (line_count),
    .wr_error   (wr_error)
  );

  int checks = 0;
  int errors = 0;

  // Slave-owned state
  int           aw_cnt, w_cnt, b_cnt, viol, cyc, aw_cyc, w_cyc, awv_run;
  logic         pend_aw, pend_w, aw_wait, w_wait;
  logic [14:0]  aw_wait_addr, cap_addr;
  logic [511:0] w_wait_data, cap_data;
  logic [63:0]  cap_strb;
  // Main-owned slave controls
  int stall_len = 0;
  int err_at = -1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin : slave
    logic hs_b;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; viol = 0; cyc = 0; aw_cyc = 0; w_cyc = 0; awv_run = 0;
    pend_aw = 0; pend_w = 0; aw_wait = 0; w_wait = 0;
    aw_wait_addr = '0; w_wait_data = '0; cap_addr = '0; cap_data = '0; cap_strb = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; pend_aw = 0; pend_w = 0;
        aw_wait = 0; w_wait = 0; awv_run = 0;
        #1;
        axi.bvalid = 1'b0;
        axi.awready = 1'b1;
      end else begin
        if (aw_wait && (!axi.awvalid || axi.awaddr !== aw_wait_addr)) viol++;
        if (w_wait && (!axi.wvalid || axi.wdata !== w_wait_data)) viol++;
        if (axs.tready && (w_cnt != b_cnt)) viol++;
        aw_wait = axi.awvalid && !axi.awready;  aw_wait_addr = axi.awaddr;
        w_wait  = axi.wvalid && !axi.wready;    w_wait_data  = axi.wdata;
        hs_b = axi.bvalid && axi.bready;
        if (axi.awvalid && axi.awready) begin
          cap_addr = axi.awaddr; aw_cnt++; aw_cyc = cyc; pend_aw = 1;
        end
        if (axi.wvalid && axi.wready) begin
          cap_data = axi.wdata; cap_strb = axi.wstrb; w_cnt++; w_cyc = cyc; pend_w = 1;
        end
        if (hs_b) b_cnt++;
        if (aw_cnt - b_cnt > 1) viol++;
        #1;
        if (hs_b) axi.bvalid = 1'b0;
        if (pend_aw && pend_w && !axi.bvalid) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_cnt == err_at) ? 2'b10 : 2'b00;
          pend_aw = 0; pend_w = 0;
        end
        axi.awready = (awv_run >= stall_len);
        if (axi.awvalid) awv_run++; else awv_run = 0;
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic got;
    got = 1'b0;
    axs.tdata = d; axs.tkeep = k; axs.tlast = l; axs.tvalid = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(posedge clk);
      got = axs.tready;
      @(negedge clk);
    end
    axs.tvalid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL tready_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_b(input int target);
    int n;
    n = 0;
    while (b_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (b_cnt < target) begin
      checks++; errors++;
      $display("FAIL b_timeout actual=%0d required=%0d", b_cnt, target);
    end
  endtask

  task automatic send_line(input logic [63:0] base);
    for (int i = 0; i < 8; i++) send_beat(base + 64'(i), 8'hFF, i == 7);
  endtask

  typedef struct {
    int          nbeats;
    logic [63:0] base;
    logic [7:0]  lastkeep;
    logic        last;
    logic [14:0] exp_addr;
    logic [63:0] exp_strb;
    logic [15:0] exp_pkt;
    logic [15:0] exp_line;
    logic [14:0] exp_ptr;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    vec_t         vt [5];
    logic [511:0] exp_d;
    int           b0;

    vt[0] = '{8, 64'h0,         8'hFF, 1'b1, 15'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 16'd1, 15'h0040};
    vt[1] = '{3, 64'h100,       8'h0F, 1'b1, 15'h0040, 64'h0000_0000_000F_FFFF, 16'd2, 16'd2, 15'h0080};
    vt[2] = '{8, 64'h200,       8'hFF, 1'b0, 15'h0080, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 16'd3, 15'h00C0};
    vt[3] = '{2, 64'h300,       8'hFF, 1'b1, 15'h00C0, 64'h0000_0000_0000_FFFF, 16'd3, 16'd4, 15'h0100};
    vt[4] = '{1, 64'hDEAD_0000, 8'h00, 1'b1, 15'h0100, 64'h0,                   16'd4, 16'd5, 15'h0140};

    axs.tvalid = 1'b0; axs.tdata = '0; axs.tkeep = '0; axs.tlast = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", axs.tready, 1'b0);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.bready}, 3'b000);
    chk("rst_ptr", wr_ptr, 15'h0000);
    chk("rst_counts", {pkt_count, line_count, wr_error}, 33'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fill_tready", axs.tready, 1'b1);
    chk("const_aw", {axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.awprot, axi.awlock, axi.wlast},
        {8'd0, 3'b110, 2'b01, 4'b0011, 3'd0, 1'b0, 1'b1});

    for (int v = 0; v < 5; v++) begin
      b0 = b_cnt;
      for (int i = 0; i < vt[v].nbeats; i++)
        send_beat(vt[v].base + 64'(i), (i == vt[v].nbeats - 1) ? vt[v].lastkeep : 8'hFF,
                  vt[v].last && (i == vt[v].nbeats - 1));
      if (v == 0) begin
        chk("valid_after_close", {axi.awvalid, axi.wvalid, axs.tready}, 3'b110);
      end
      wait_b(b0 + 1);
      exp_d = '0;
      for (int i = 0; i < vt[v].nbeats; i++) exp_d[i*64 +: 64] = vt[v].base + 64'(i);
      chk($sformatf("v%0d_addr", v), cap_addr, vt[v].exp_addr);
      chk($sformatf("v%0d_strb", v), cap_strb, vt[v].exp_strb);
      chk($sformatf("v%0d_data", v), cap_data, exp_d);
      chk($sformatf("v%0d_pkt", v), pkt_count, vt[v].exp_pkt);
      chk($sformatf("v%0d_line", v), line_count, vt[v].exp_line);
      chk($sformatf("v%0d_ptr", v), wr_ptr, vt[v].exp_ptr);
    end

    // AW stalled for 5 cycles while W completes immediately
    stall_len = 5;
    b0 = b_cnt;
    send_line(64'h400);
    wait_b(b0 + 1);
    stall_len = 0;
    repeat (4) @(negedge clk);
    chk("stall_w_first", aw_cyc - w_cyc, 5);
    chk("stall_addr", cap_addr, 15'h0140);
    chk("stall_one_b", b_cnt - b0, 1);
    chk("stall_counts", {pkt_count, line_count, wr_ptr}, {16'd5, 16'd6, 15'h0180});

    // Error response on the second of three lines
    err_at = b_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      b0 = b_cnt;
      send_line(64'h500 + 64'(k * 8));
      wait_b(b0 + 1);
      chk($sformatf("err_flag%0d", k), wr_error, (k >= 1) ? 1'b1 : 1'b0);
      chk($sformatf("err_ptr%0d", k), wr_ptr, 15'h0180 + 15'((k + 1) * 64));
    end
    err_at = -1;

    // Reset while awvalid is pending
    stall_len = 20;
    send_line(64'h600);
    @(negedge clk);
    chk("pre_rst_awvalid", axi.awvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_drop", {axi.awvalid, axi.wvalid, axs.tready}, 3'b000);
    stall_len = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ptr", wr_ptr, 15'h0000);
    chk("post_rst_counts", {pkt_count, line_count, wr_error}, 33'd0);
    chk("post_rst_tready", axs.tready, 1'b1);

    // 512 back-to-back lines wrap the region
    for (int l = 0; l < 512; l++) send_line(64'(l * 8));
    wait_b(512);
    chk("wrap_last_addr", cap_addr, 15'h7FC0);
    chk("wrap_ptr", wr_ptr, 15'h0000);
    chk("wrap_line", line_count, 16'd512);
    chk("wrap_pkt", pkt_count, 16'd512);
    chk("wrap_aw_cnt", aw_cnt, 512);

    chk("protocol_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
